// File: rtl/key_event_arbiter.sv
// Key front end: per-key sync + debounce, press-to-event conversion, round-robin
// arbitration onto a single event path, and a small FIFO with a valid/ready handshake.
module key_event_arbiter #(
    parameter int unsigned NKEYS           = 12,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] keystroke,
    output logic             key_valid,
    output logic [3:0]       key_code,
    input  logic             key_ready,
    output logic [NKEYS-1:0] keys_stable,
    output logic             overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [NKEYS-1:0] sync1_q, sync2_q;
    logic [NKEYS-1:0] stable_q, stable_d;
    logic [NKEYS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q [NKEYS];
    logic [CNT_W-1:0] cnt_d [NKEYS];
    logic [3:0]       rr_ptr_q, rr_ptr_d;
    logic             overflow_q, overflow_d;

    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;

    logic [NKEYS-1:0] rise, grant_mask;
    logic [4:0]       cand;
    logic             grant_hit;
    logic [3:0]       grant_idx;
    logic             full, push, pop;

    // Debounce: a level change is accepted only after persisting DEBOUNCE_CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NKEYS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = stable_d & ~stable_q;

    // Round-robin search over the registered pending bits, starting at rr_ptr.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NKEYS; k++) begin
            cand = 5'(rr_ptr_q) + 5'(k);
            if (cand >= 5'(NKEYS)) begin
                cand = cand - 5'(NKEYS);
            end
            if (!grant_hit && pending_q[cand[3:0]]) begin
                grant_hit = 1'b1;
                grant_idx = cand[3:0];
            end
        end
    end

    assign full      = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign push      = grant_hit && !full;
    assign key_valid = (count_q != '0);
    assign pop       = key_valid && key_ready;

    always_comb begin
        grant_mask = '0;
        if (push) begin
            grant_mask = NKEYS'(1) << grant_idx;
        end
        // A press on a key whose previous event is still pending is lost.
        pending_d  = (pending_q & ~grant_mask) | (rise & ~pending_q);
        overflow_d = overflow_q | (|(rise & pending_q));
        rr_ptr_d   = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (grant_idx == 4'(NKEYS - 1)) ? 4'd0 : grant_idx + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < NKEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= keystroke;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < NKEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end

    assign key_code    = key_valid ? mem_q[rd_ptr_q] : 4'd0;
    assign keys_stable = stable_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Self-checking bench for key_event_arbiter: expected key codes are queued as
// presses are driven and compared as the DUT hands events over.
`timescale 1ns/100ps
module tb_key_event_arbiter;

    logic        clk;
    logic        rst;
    logic [11:0] keystroke;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic [11:0] keys_stable;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned sb[$];

    key_event_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .keystroke  (keystroke),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .keys_stable(keys_stable),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard consumer: every handshake must match the oldest expected code.
    always @(negedge clk) begin
        if (!rst && key_valid === 1'b1 && key_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_event", {28'b0, key_code}, 32'hFFFF_FFFF);
            end else begin
                check("event_code", {28'b0, key_code}, 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        keystroke = 12'h001;
        key_ready = 1'b1;
        tick(2);
        check("rst_valid", {31'b0, key_valid}, 32'd0);
        check("rst_code", {28'b0, key_code}, 32'd0);
        check("rst_stable", {20'b0, keys_stable}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);

        // Single press: stable after edge 5, event after edge 6.
        rst = 1'b0;
        sb.push_back(0);
        tick(5);
        check("t1_stable_e4", {20'b0, keys_stable}, 32'h000);
        tick(1);
        check("t1_stable_e5", {20'b0, keys_stable}, 32'h001);
        check("t1_valid_e5", {31'b0, key_valid}, 32'd0);
        tick(1);
        check("t1_valid_e6", {31'b0, key_valid}, 32'd1);
        check("t1_code_e6", {28'b0, key_code}, 32'd0);
        tick(1);
        check("t1_valid_e7", {31'b0, key_valid}, 32'd0);
        tick(10);
        keystroke = 12'h000;
        tick(10);
        check("t1_released", {20'b0, keys_stable}, 32'h000);

        // Glitch shorter than the debounce window is ignored.
        keystroke = 12'h002;
        tick(3);
        keystroke = 12'h000;
        tick(10);
        check("glitch_stable", {20'b0, keys_stable}, 32'h000);
        check("glitch_valid", {31'b0, key_valid}, 32'd0);
        sb.push_back(1);
        keystroke = 12'h002;
        tick(10);
        check("hold_stable", {20'b0, keys_stable}, 32'h002);
        keystroke = 12'h000;
        tick(10);

        // Simultaneous presses from rr_ptr=0, then wrap-around from rr_ptr=9.
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        tick(1);
        keystroke = 12'h111;
        sb.push_back(0);
        sb.push_back(4);
        sb.push_back(8);
        tick(6);
        check("rr_valid_e5", {31'b0, key_valid}, 32'd0);
        tick(1);
        check("rr_code_a", {28'b0, key_code}, 32'd0);
        tick(1);
        check("rr_code_b", {28'b0, key_code}, 32'd4);
        tick(1);
        check("rr_code_c", {28'b0, key_code}, 32'd8);
        tick(1);
        check("rr_valid_done", {31'b0, key_valid}, 32'd0);
        keystroke = 12'h000;
        tick(10);
        keystroke = 12'h404;
        sb.push_back(10);
        sb.push_back(2);
        tick(12);
        keystroke = 12'h000;
        tick(10);

        // FIFO full: grants stop, key 4 stays pending, a re-press overflows.
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        tick(1);
        key_ready = 1'b0;
        keystroke = 12'h01F;
        for (int i = 0; i < 5; i++) sb.push_back(i);
        tick(12);
        check("full_valid", {31'b0, key_valid}, 32'd1);
        check("full_code", {28'b0, key_code}, 32'd0);
        check("full_no_ovf", {31'b0, overflow}, 32'd0);
        keystroke = 12'h00F;
        tick(8);
        keystroke = 12'h01F;
        tick(8);
        check("full_ovf", {31'b0, overflow}, 32'd1);
        check("full_code_held", {28'b0, key_code}, 32'd0);
        key_ready = 1'b1;
        tick(12);
        check("drain_valid", {31'b0, key_valid}, 32'd0);
        check("ovf_sticky", {31'b0, overflow}, 32'd1);
        keystroke = 12'h000;
        tick(10);

        // Async reset with events queued and pending discards everything.
        key_ready = 1'b0;
        keystroke = 12'h03F;
        tick(14);
        check("pre_rst_valid", {31'b0, key_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, key_valid}, 32'd0);
        check("arst_stable", {20'b0, keys_stable}, 32'd0);
        check("arst_ovf", {31'b0, overflow}, 32'd0);
        check("arst_code", {28'b0, key_code}, 32'd0);
        #1 rst = 1'b0;
        key_ready = 1'b1;
        for (int i = 0; i < 6; i++) sb.push_back(i);
        tick(6);
        check("post_rst_stable", {20'b0, keys_stable}, 32'h03F);
        check("post_rst_valid_e5", {31'b0, key_valid}, 32'd0);
        tick(1);
        check("post_rst_valid_e6", {31'b0, key_valid}, 32'd1);
        check("post_rst_code", {28'b0, key_code}, 32'd0);
        tick(12);
        keystroke = 12'h000;
        tick(10);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
